// File: rtl/load_store_unit.sv
// load_store_unit
//
// Memory-access stage that sits after the ALU. It takes the effective
// address, the load/store opcode and the store data. It then runs a
// request/grant/response handshake with data memory and returns the
// extended load result for writeback. Byte order is little-endian.
//
// Misaligned halfword/word accesses and illegal opcodes finish
// immediately with a single done pulse and never touch memory. All
// outputs are registered.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start                 memory op presented (sampled only in IDLE)
//   opcode                MIPS opcode (LB/LH/LW/LBU/LHU/SB/SH/SW)
//   addr                  effective address
//   wdata                 store data (rt)
//   busy                  access outstanding; pipeline holds while high
//   done                  one-cycle completion pulse
//   misaligned            valid with done; access was aborted
//   rdata                 extended load result, updated on load completion only
//   mem_req/we/addr/be/wdata  request to data memory, held until mem_gnt
//   mem_gnt               request accepted
//   mem_rvalid, mem_rdata load response (sampled only while waiting)
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state;
  size_t       size_q;
  logic        unsigned_q;
  logic [1:0]  off_q;

  // Opcode decode of the incoming request
  logic        dec_legal;
  logic        dec_load;
  logic        dec_unsigned;
  size_t       dec_size;
  logic        dec_misaligned;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;

  always_comb begin
    dec_legal    = 1'b1;
    dec_load     = 1'b1;
    dec_unsigned = 1'b0;
    dec_size     = SZ_WORD;
    case (opcode)
      6'h20: dec_size = SZ_BYTE;
      6'h21: dec_size = SZ_HALF;
      6'h23: dec_size = SZ_WORD;
      6'h24: begin dec_size = SZ_BYTE; dec_unsigned = 1'b1; end
      6'h25: begin dec_size = SZ_HALF; dec_unsigned = 1'b1; end
      6'h28: begin dec_size = SZ_BYTE; dec_load = 1'b0; end
      6'h29: begin dec_size = SZ_HALF; dec_load = 1'b0; end
      6'h2B: begin dec_size = SZ_WORD; dec_load = 1'b0; end
      default: dec_legal = 1'b0;
    endcase
  end

  // Alignment check, byte enables and store-lane replication.
  // Loads drive the same enable pattern as stores.
  always_comb begin
    dec_misaligned = 1'b0;
    dec_be         = 4'b1111;
    dec_wdata      = wdata;
    case (dec_size)
      SZ_BYTE: begin
        dec_be    = 4'b0001 << addr[1:0];
        dec_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        dec_misaligned = addr[0];
        dec_be         = addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata      = {2{wdata[15:0]}};
      end
      default: begin
        dec_misaligned = (addr[1:0] != 2'b00);
        dec_be         = 4'b1111;
        dec_wdata      = wdata;
      end
    endcase
  end

  // Load extraction. Shifting the word right by 8*offset puts the
  // addressed byte or half in the low bits. Halves are always 2-aligned
  // here, so one shifter covers both sizes.
  logic [31:0] shifted;
  logic [31:0] load_val;

  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_val = mem_rdata;
    case (size_q)
      SZ_BYTE: load_val = unsigned_q ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = unsigned_q ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  // Main control FSM. busy mirrors the next state so that it is high
  // exactly while the FSM is outside IDLE. done defaults low, which makes
  // it a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      off_q      <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      rdata      <= 32'h0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!dec_legal) begin
              done       <= 1'b1;
              misaligned <= 1'b0;
            end else if (dec_misaligned) begin
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              misaligned <= 1'b0;
              size_q     <= dec_size;
              unsigned_q <= dec_unsigned;
              off_q      <= addr[1:0];
              mem_req    <= 1'b1;
              mem_we     <= ~dec_load;
              mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
              mem_be     <= dec_be;
              mem_wdata  <= dec_wdata;
              busy       <= 1'b1;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata <= load_val;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Table-driven bench for load_store_unit. Each vector carries the
// expected byte enables, store lanes, load result and abort flag as
// constants. Completion results go through a scoreboard queue. The
// entry is pushed when start is driven and popped at the done pulse.
// The reset-in-WAIT case is written out by hand.
module tb_load_store_unit;

  localparam int ADDR_W = 32;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              misaligned;
  logic [31:0]       rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          gnt_dly;
    int          rv_dly;
    logic        is_store;
    logic        exp_access;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    string       name;
    logic        mis;
    logic [31:0] rdata;
  } sb_t;

  sb_t         sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Pops the oldest expected completion and compares it with the outputs
  task automatic sbPop(input string tag);
    sb_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: done with empty scoreboard", tag);
    end else begin
      e = sbq.pop_front();
      checkOutput({e.name, " misaligned"}, {31'h0, misaligned}, {31'h0, e.mis});
      checkOutput({e.name, " rdata"}, rdata, e.rdata);
    end
  endtask

  // One cycle of busy-time interference: a start pulse that must be ignored
  task automatic busyCycle(input vec_t v, input string phase);
    start  = 1'b1;
    opcode = OP_SW;
    addr   = 32'hFFFF_FFF0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({v.name, " ", phase, " busy"}, {31'h0, busy}, 32'h1);
    checkOutput({v.name, " ", phase, " done"}, {31'h0, done}, 32'h0);
  endtask

  task automatic applyStimulus(input vec_t v);
    sb_t e;
    e.name  = v.name;
    e.mis   = v.exp_mis;
    e.rdata = (v.exp_access && !v.is_store) ? v.exp_rdata : last_rdata;
    start  = 1'b1;
    opcode = v.op;
    addr   = v.addr;
    wdata  = v.wdata;
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    if (!v.exp_access) begin
      checkOutput({v.name, " done"}, {31'h0, done}, 32'h1);
      checkOutput({v.name, " no req"}, {31'h0, mem_req}, 32'h0);
      checkOutput({v.name, " busy"}, {31'h0, busy}, 32'h0);
      sbPop(v.name);
    end else begin
      checkOutput({v.name, " req"}, {31'h0, mem_req}, 32'h1);
      checkOutput({v.name, " busy"}, {31'h0, busy}, 32'h1);
      checkOutput({v.name, " done low"}, {31'h0, done}, 32'h0);
      checkOutput({v.name, " we"}, {31'h0, mem_we}, {31'h0, v.is_store});
      checkOutput({v.name, " mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
      checkOutput({v.name, " be"}, {28'h0, mem_be}, {28'h0, v.exp_be});
      if (v.is_store)
        checkOutput({v.name, " mem_wdata"}, mem_wdata, v.exp_wdata);
      for (int i = 0; i < v.gnt_dly; i++) begin
        busyCycle(v, "gnt wait");
        checkOutput({v.name, " req held"}, {31'h0, mem_req}, 32'h1);
        checkOutput({v.name, " addr held"}, mem_addr, v.addr & 32'hFFFF_FFFC);
        checkOutput({v.name, " be held"}, {28'h0, mem_be}, {28'h0, v.exp_be});
        checkOutput({v.name, " we held"}, {31'h0, mem_we}, {31'h0, v.is_store});
      end
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      checkOutput({v.name, " req dropped"}, {31'h0, mem_req}, 32'h0);
      if (v.is_store) begin
        checkOutput({v.name, " done"}, {31'h0, done}, 32'h1);
        checkOutput({v.name, " busy end"}, {31'h0, busy}, 32'h0);
        sbPop(v.name);
      end else begin
        checkOutput({v.name, " busy wait"}, {31'h0, busy}, 32'h1);
        checkOutput({v.name, " done wait"}, {31'h0, done}, 32'h0);
        for (int i = 0; i < v.rv_dly; i++)
          busyCycle(v, "rvalid wait");
        mem_rvalid = 1'b1;
        mem_rdata  = v.mrdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        checkOutput({v.name, " done"}, {31'h0, done}, 32'h1);
        checkOutput({v.name, " busy end"}, {31'h0, busy}, 32'h0);
        sbPop(v.name);
        last_rdata = v.exp_rdata;
      end
    end
  endtask

  vec_t vecs[$];

  task automatic addVec(input string n, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] mrd, input int gd,
                        input int rd, input logic st, input logic acc, input logic mis,
                        input logic [3:0] be, input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.name = n; v.op = op; v.addr = a; v.wdata = wd; v.mrdata = mrd;
    v.gnt_dly = gd; v.rv_dly = rd; v.is_store = st; v.exp_access = acc;
    v.exp_mis = mis; v.exp_be = be; v.exp_wdata = ewd; v.exp_rdata = erd;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    opcode     = 6'h0;
    addr       = 32'h0;
    wdata      = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    //      name         op      addr         wdata         mrdata        gd rd st acc mis be       exp_wdata     exp_rdata
    addVec("sw_basic",   OP_SW,  32'h0000_1004, 32'hDEAD_BEEF, 32'h0,         0, 0, 1, 1, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    addVec("lb_neg",     OP_LB,  32'h0000_1003, 32'h0,         32'h80FF_0000, 0, 0, 0, 1, 0, 4'b1000, 32'h0,         32'hFFFF_FF80);
    addVec("lbu",        OP_LBU, 32'h0000_1003, 32'h0,         32'h80FF_0000, 0, 0, 0, 1, 0, 4'b1000, 32'h0,         32'h0000_0080);
    addVec("sb_lane2",   OP_SB,  32'h0000_3002, 32'h1234_5678, 32'h0,         1, 0, 1, 1, 0, 4'b0100, 32'h7878_7878, 32'h0);
    addVec("lh_hi",      OP_LH,  32'h0000_2002, 32'h0,         32'h8001_1234, 0, 0, 0, 1, 0, 4'b1100, 32'h0,         32'hFFFF_8001);
    addVec("lhu_hi",     OP_LHU, 32'h0000_2002, 32'h0,         32'h8001_1234, 0, 1, 0, 1, 0, 4'b1100, 32'h0,         32'h0000_8001);
    addVec("sh_mis",     OP_SH,  32'h0000_2001, 32'h1111_1111, 32'h0,         0, 0, 1, 0, 1, 4'b0000, 32'h0,         32'h0);
    addVec("lw_mis",     OP_LW,  32'h0000_2002, 32'h0,         32'h0,         0, 0, 0, 0, 1, 4'b0000, 32'h0,         32'h0);
    addVec("sh_hi",      OP_SH,  32'h0000_3002, 32'hAABB_CCDD, 32'h0,         0, 0, 1, 1, 0, 4'b1100, 32'hCCDD_CCDD, 32'h0);
    addVec("lw_slow",    OP_LW,  32'h0000_4000, 32'h0,         32'hCAFE_F00D, 3, 2, 0, 1, 0, 4'b1111, 32'h0,         32'hCAFE_F00D);
    addVec("illegal",    6'h00,  32'h0000_4000, 32'h0,         32'h0,         0, 0, 0, 0, 0, 4'b0000, 32'h0,         32'h0);
    addVec("lb_pos",     OP_LB,  32'h0000_5000, 32'h0,         32'h0000_007F, 0, 0, 0, 1, 0, 4'b0001, 32'h0,         32'h0000_007F);
    addVec("lh_lo",      OP_LH,  32'h0000_5000, 32'h0,         32'h1234_FFFE, 0, 0, 0, 1, 0, 4'b0011, 32'h0,         32'hFFFF_FFFE);
    addVec("sb_lane1",   OP_SB,  32'h0000_5001, 32'h0000_00AB, 32'h0,         0, 0, 1, 1, 0, 4'b0010, 32'hABAB_ABAB, 32'h0);
    addVec("lb_lane1",   OP_LB,  32'h0000_6001, 32'h0,         32'h0000_8000, 0, 0, 0, 1, 0, 4'b0010, 32'h0,         32'hFFFF_FF80);
    addVec("sw_mis",     OP_SW,  32'h0000_6001, 32'h0,         32'h0,         0, 0, 1, 0, 1, 4'b0000, 32'h0,         32'h0);
    addVec("sh_lo",      OP_SH,  32'h0000_7000, 32'h0000_BEEF, 32'h0,         0, 0, 1, 1, 0, 4'b0011, 32'hBEEF_BEEF, 32'h0);

    // Reset state
    #12;
    checkOutput("reset busy", {31'h0, busy}, 32'h0);
    checkOutput("reset done", {31'h0, done}, 32'h0);
    checkOutput("reset req", {31'h0, mem_req}, 32'h0);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset be", {28'h0, mem_be}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vectors run back to back: each start lands in the previous done cycle
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Idle: no spurious completions or requests
    @(posedge clk); #1;
    checkOutput("idle done", {31'h0, done}, 32'h0);
    checkOutput("idle req", {31'h0, mem_req}, 32'h0);
    checkOutput("idle rdata held", rdata, last_rdata);

    // Reset while waiting for load data, then a late rvalid
    start = 1'b1; opcode = OP_LW; addr = 32'h0000_8000;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("rst seq req", {31'h0, mem_req}, 32'h1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    checkOutput("rst seq in wait", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst async busy", {31'h0, busy}, 32'h0);
    checkOutput("rst async rdata", rdata, 32'h0);
    checkOutput("rst async req", {31'h0, mem_req}, 32'h0);
    checkOutput("rst async done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    checkOutput("late rvalid done", {31'h0, done}, 32'h0);
    checkOutput("late rvalid rdata", rdata, 32'h0);
    checkOutput("late rvalid busy", {31'h0, busy}, 32'h0);
    last_rdata = 32'h0;
    begin
      vec_t v;
      v.name = "lw_after_rst"; v.op = OP_LW; v.addr = 32'h0000_9008; v.wdata = 32'h0;
      v.mrdata = 32'h0BAD_F00D; v.gnt_dly = 0; v.rv_dly = 0; v.is_store = 1'b0;
      v.exp_access = 1'b1; v.exp_mis = 1'b0; v.exp_be = 4'b1111; v.exp_wdata = 32'h0;
      v.exp_rdata = 32'h0BAD_F00D;
      applyStimulus(v);
    end
    @(posedge clk); #1;
    checkOutput("final done low", {31'h0, done}, 32'h0);
    checkOutput("scoreboard empty", sbq.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage downstream of the ALU: consumes the ALU's effective address (base + sign-extended offset) with the load/store opcode and `rt` data, runs a request/grant/response handshake with data memory, and returns the extended load result for writeback. It stalls the pipeline via `busy` while an access is outstanding and flags misaligned accesses without touching memory. Byte order is little-endian.

## Interface
- `ADDR_W`, 32, width of effective and memory address

- `clk` in 1, rising-edge clock
- `rst_n` in 1, asynchronous active-low reset
- `start` in 1, valid memory op presented this cycle (sampled only in IDLE)
- `opcode` in 6, MIPS opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B
- `addr` in ADDR_W, effective address from the ALU
- `wdata` in 32, store data (`rt`)
- `busy` out 1, state != IDLE; pipeline holds EX/MEM while high
- `done` out 1, one-cycle completion pulse
- `misaligned` out 1, valid with `done`; access aborted
- `rdata` out 32, extended load result; valid with `done` for loads, otherwise held
- `mem_req` out 1, memory request
- `mem_we` out 1, 1 for store
- `mem_addr` out ADDR_W, word address: `addr` with [1:0] forced to 0
- `mem_be` out 4, byte enables
- `mem_wdata` out 32, lane-replicated store data
- `mem_gnt` in 1, request accepted this cycle
- `mem_rvalid` in 1, load data valid
- `mem_rdata` in 32, load word

## Operation
- States: IDLE, REQ, WAIT. All outputs are registered; reset drives IDLE and all outputs to 0.
- IDLE, `start`=1:
  - Illegal opcode: `done`=1 next cycle, no access, `misaligned`=0.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): `done`=1 and `misaligned`=1 next cycle, no access.
  - Otherwise: latch op, byte offset, `mem_*`; go to REQ with `mem_req`=1.
- REQ: `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` are held stable until `mem_gnt`.
  - Grant on a store: `mem_req`=0, `done`=1 next cycle, return to IDLE.
  - Grant on a load: `mem_req`=0, go to WAIT.
- WAIT: on `mem_rvalid`, `rdata` is loaded with the extracted and extended value, `done`=1 next cycle, return to IDLE. `mem_rvalid` outside WAIT is ignored.
- Byte enables, for offset k=addr[1:0]:
  - byte: `1<<k`
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - The same byte-enable pattern is driven for loads.
- Store data: SB replicates wdata[7:0] across all four lanes; SH replicates wdata[15:0] across both halves; SW passes wdata through.
- Load extract: byte from lane k = `mem_rdata[8k+7:8k]`; half = `mem_rdata[16*addr[1]+15 : 16*addr[1]]`.
  - LB, LH: sign-extend to 32 bits.
  - LBU, LHU: zero-extend.
  - LW: full word.
- `rdata` changes only on load completion.
- `rst_n` low mid-access: asynchronously clears `mem_req`, `done`, `busy`, `rdata`, and the state. Any pending grant or response is abandoned; a late `mem_rvalid` after reset is ignored.

## Timing
- `done` is high for exactly one cycle per accepted `start`.
- `start` in IDLE is accepted even in the cycle `done` is high, giving back-to-back throughput.
- `start` is ignored while `busy`=1.
- Minimum latency, with `start` in cycle 0:
  - Misaligned or illegal: `done` in cycle 1.
  - Store with `mem_gnt` in cycle 1: `done` in cycle 2.
  - Load with `mem_gnt` in cycle 1 and `mem_rvalid` in cycle 2: `done` in cycle 3.
- Each cycle without `mem_gnt` or `mem_rvalid` adds one cycle of latency; there is no timeout.
- `mem_gnt` and `mem_rvalid` may not occur in the same cycle for one access; `rvalid` is sampled only from WAIT.

## Test plan
- SW addr=0x0000_1004, wdata=0xDEADBEEF, gnt in cycle 1 -> `mem_req` in cycle 1, mem_addr=0x1004, be=1111, mem_wdata=0xDEADBEEF, `done` in cycle 2, busy high in cycle 1 only.
- LB addr=0x1003, mem_rdata=0x80FF_0000 -> be=1000, rdata=0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
- LH addr=0x2002, mem_rdata=0x8001_1234 -> be=1100, rdata=0xFFFF_8001; LHU -> 0x0000_8001.
- SH addr=0x2001 -> no `mem_req`, `done`=`misaligned`=1 in cycle 1; LW addr=0x2002 -> same behaviour.
- Grant withheld 3 cycles and rvalid withheld 2 cycles on a LW -> `mem_*` stable throughout REQ, `busy` held, `start` pulses during busy ignored, exactly one `done`.
- `rst_n` low while in WAIT, then `mem_rvalid` after release -> all outputs 0, no `done`, rdata=0; the next LW completes normally.
